// File: rtl/if_id_skid_reg.sv
// IF/ID boundary: 2-entry skid buffer carrying {instr, pc4} from fetch to decode.
// Optional performance counters are enabled with `define IFID_PERF_CNT_EN.
module if_id_skid_reg #(
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc4,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc4,
  input  logic              out_ready
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  localparam int unsigned DEPTH = 2;

  logic [1:0]        count_reg, count_next;
  logic              wr_ptr_reg, wr_ptr_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic [DATA_W-1:0] instr_reg [DEPTH];
  logic [DATA_W-1:0] pc4_reg   [DEPTH];
  logic [DEPTH-1:0]  wr_en;
  logic              push;
  logic              pop;

  // Both status flags come straight from the registered count, so fetch
  // never sees a combinational path from out_ready.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);

  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push & (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      count_next  = 2'd0;
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_next = ~wr_ptr_reg;
      if (pop)  rd_ptr_next = ~rd_ptr_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Flush leaves the payload untouched; the empty count already masks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_reg[i] <= '0;
        pc4_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          instr_reg[i] <= in_instr;
          pc4_reg[i]   <= in_pc4;
        end
      end
    end
  end

  assign out_instr = out_valid ? instr_reg[rd_ptr_reg] : NOP_WORD;
  assign out_pc4   = out_valid ? pc4_reg[rd_ptr_reg]   : '0;

`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_cycles_reg;
  logic [15:0] flush_count_reg;

  // Saturating counters; flush only feeds flush_count, it never clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= 16'd0;
      flush_count_reg  <= 16'd0;
    end else begin
      if (in_valid && !in_ready && !(&stall_cycles_reg))
        stall_cycles_reg <= stall_cycles_reg + 16'd1;
      if (flush && !(&flush_count_reg))
        flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`endif

endmodule
